hdd_sector_server: RTL

HDD_SECTOR_SERVER -- requirements
Module: hdd_sector_server

---
 rtl/hdd_sector_server_pkg.sv | 23 ++
 rtl/hdd_sector_server.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hdd_sector_server_pkg.sv
// Shared types and sector geometry for the HDD sector server.
package hdd_sector_server_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = 9;
    localparam int LBA_W        = 32;
    localparam int SEC_ADDR_W   = LBA_W + SECTOR_SHIFT;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        XFER_RD,
        XFER_WR,
        REARM
    } state_t;

    // Byte address of the last byte of a sector, kept at full width so the
    // range check can see any carry past the image-memory address space.
    function automatic logic [SEC_ADDR_W-1:0] sector_last_byte(input logic [LBA_W-1:0] lba);
        return {lba, {SECTOR_SHIFT{1'b1}}};
    endfunction

endpackage

// File: rtl/hdd_sector_server.sv
// Serves 512-byte sector reads/writes between a client sector buffer and a
// byte-wide image memory; sd_ack frames the whole 513-cycle transfer.
module hdd_sector_server
    import hdd_sector_server_pkg::*;
#(
    parameter int IMG_AW    = 25,
    parameter int ACK_DELAY = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    input  logic [63:0]       img_size,
    output logic [IMG_AW-1:0] img_addr,
    output logic              img_rd,
    input  logic [7:0]        img_rdata,
    output logic              img_we,
    output logic [7:0]        img_wdata,
    output logic              busy
);

    localparam logic [7:0] DLY_LAST = 8'(ACK_DELAY - 1);
    localparam logic [9:0] K_LAST   = 10'(SECTOR_BYTES);

    state_t            state, state_nxt;
    logic              rd_dir;
    logic              in_range;
    logic [IMG_AW-1:0] img_base;
    logic [7:0]        dly;
    logic [9:0]        k;
    logic [8:0]        k_lo;
    logic [8:0]        k_prev;
    logic              accept;
    logic              xfer;

    assign accept = (state == IDLE) && (sd_rd || sd_wr);
    assign xfer   = (state == XFER_RD) || (state == XFER_WR);
    assign k_lo   = k[8:0];
    assign k_prev = k_lo - 9'd1;
    assign sd_ack = xfer;
    assign busy   = (state != IDLE);

    // Request is frozen at accept: direction, sector base and range verdict.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_dir   <= 1'b0;
            in_range <= 1'b0;
            img_base <= '0;
            dly      <= '0;
            k        <= '0;
        end else begin
            state <= state_nxt;
            dly   <= (state == WAIT) ? dly + 8'd1 : 8'd1;
            k     <= xfer ? k + 10'd1 : 10'd0;
            if (accept) begin
                rd_dir   <= sd_rd;
                img_base <= IMG_AW'({sd_lba, {SECTOR_SHIFT{1'b0}}});
                in_range <= ({32'd0, sd_lba} < (img_size >> SECTOR_SHIFT)) &&
                            ((sector_last_byte(sd_lba) >> IMG_AW) == '0);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    if (ACK_DELAY == 1)
                        state_nxt = sd_rd ? XFER_RD : XFER_WR;
                    else
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dly == DLY_LAST)
                    state_nxt = rd_dir ? XFER_RD : XFER_WR;
            end
            XFER_RD, XFER_WR: begin
                if (k == K_LAST)
                    state_nxt = REARM;
            end
            REARM: begin
                if (!sd_rd && !sd_wr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cycle k issues byte k toward its source; cycle k+1 lands it at the sink.
    always_comb begin
        sd_buff_wr   = (state == XFER_RD) && (k != 10'd0);
        img_rd       = (state == XFER_RD) && !k[9] && in_range;
        img_we       = (state == XFER_WR) && (k != 10'd0) && in_range;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        img_addr     = '0;
        img_wdata    = '0;
        if (sd_buff_wr) begin
            sd_buff_addr = k_prev;
            sd_buff_dout = in_range ? img_rdata : 8'h00;
        end else if ((state == XFER_WR) && !k[9]) begin
            sd_buff_addr = k_lo;
        end
        if (img_rd) begin
            img_addr = img_base + IMG_AW'(k_lo);
        end else if (img_we) begin
            img_addr  = img_base + IMG_AW'(k_prev);
            img_wdata = sd_buff_din;
        end
    end

endmodule
